// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, branch flushes,
// multi-cycle load-use bubbles, MDU busy stalls and stall/flush counters.
module hazard_unit_mc #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs_1_d_i,
    input  logic [REG_AW-1:0] rs_2_d_i,
    input  logic [REG_AW-1:0] rs_1_e_i,
    input  logic [REG_AW-1:0] rs_2_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic              result_src_e_i,
    input  logic              pc_src_e_i,
    input  logic              mdu_start_e_i,
    input  logic              mdu_done_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              we_reg_file_m_i,
    input  logic              we_reg_file_w_i,
    input  logic              cnt_clr_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic [1:0]        forward_1e_o,
    output logic [1:0]        forward_2e_o,
    output logic [CNT_W-1:0]  cnt_stall_o,
    output logic [CNT_W-1:0]  cnt_flush_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        MDU_BUSY
    } state_e;

    // The first bubble is issued from IDLE, so LOAD_WAIT covers the rest.
    localparam logic [1:0] WAIT_INIT =
        (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_e            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;
    logic              lw_hit;
    logic              sf, sd, se, fd, fe;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0 && we_m && rs == rd_m) begin
            sel = 2'b10;
        end else if (rs != '0 && we_w && rs == rd_w) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forward_1e_o = fwd_sel(rs_1_e_i, rd_m_i, we_reg_file_m_i,
                               rd_w_i, we_reg_file_w_i);
        forward_2e_o = fwd_sel(rs_2_e_i, rd_m_i, we_reg_file_m_i,
                               rd_w_i, we_reg_file_w_i);
    end

    assign lw_hit = result_src_e_i && (rd_e_i != '0) &&
                    ((rs_1_d_i == rd_e_i) || (rs_2_d_i == rd_e_i));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        sf = 1'b0;
        sd = 1'b0;
        se = 1'b0;
        fd = 1'b0;
        fe = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_src_e_i) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (lw_hit) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end else if (mdu_start_e_i && !mdu_done_i) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    se = 1'b1;
                    state_d = MDU_BUSY;
                end
            end
            LOAD_WAIT: begin
                sf = 1'b1;
                sd = 1'b1;
                fe = 1'b1;
                if (wait_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done_i) begin
                    state_d = IDLE;
                end else begin
                    sf = 1'b1;
                    sd = 1'b1;
                    se = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 2'd0;
            end
        endcase
    end

    // Reset must silence the pipeline controls immediately, not at the edge.
    always_comb begin
        stall_f_o = sf & ~rst_i;
        stall_d_o = sd & ~rst_i;
        stall_e_o = se & ~rst_i;
        flush_d_o = fd & ~rst_i;
        flush_e_o = fe & ~rst_i;
    end

    always_comb begin
        cnt_stall_d = cnt_stall_q;
        cnt_flush_d = cnt_flush_q;
        if (cnt_clr_i) begin
            cnt_stall_d = '0;
            cnt_flush_d = '0;
        end else begin
            if (sf && !(&cnt_stall_q)) begin
                cnt_stall_d = cnt_stall_q + 1'b1;
            end
            if ((fd || fe) && !(&cnt_flush_q)) begin
                cnt_flush_d = cnt_flush_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wait_q      <= 2'd0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign cnt_stall_o = cnt_stall_q;
    assign cnt_flush_o = cnt_flush_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: a LOAD_LAT=3 instance plus a
// LOAD_LAT=1 instance with 2-bit counters for saturation.
module tb_hazard_unit_mc;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] rs_1_d_i, rs_2_d_i, rs_1_e_i, rs_2_e_i, rd_e_i;
    logic [4:0] rd_m_i, rd_w_i;
    logic       result_src_e_i, pc_src_e_i, mdu_start_e_i, mdu_done_i;
    logic       we_reg_file_m_i, we_reg_file_w_i, cnt_clr_i;

    logic        stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o;
    logic [1:0]  forward_1e_o, forward_2e_o;
    logic [31:0] cnt_stall_o, cnt_flush_o;

    logic        l1_sf, l1_sd, l1_se, l1_fd, l1_fe;
    logic [1:0]  l1_f1, l1_f2;
    logic [1:0]  l1_cs, l1_cf;

    always #5 clk_i = ~clk_i;

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs_1_d_i(rs_1_d_i), .rs_2_d_i(rs_2_d_i),
        .rs_1_e_i(rs_1_e_i), .rs_2_e_i(rs_2_e_i), .rd_e_i(rd_e_i),
        .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i),
        .mdu_start_e_i(mdu_start_e_i), .mdu_done_i(mdu_done_i),
        .rd_m_i(rd_m_i), .rd_w_i(rd_w_i),
        .we_reg_file_m_i(we_reg_file_m_i), .we_reg_file_w_i(we_reg_file_w_i),
        .cnt_clr_i(cnt_clr_i),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .forward_1e_o(forward_1e_o), .forward_2e_o(forward_2e_o),
        .cnt_stall_o(cnt_stall_o), .cnt_flush_o(cnt_flush_o)
    );

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) dut_l1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs_1_d_i(rs_1_d_i), .rs_2_d_i(rs_2_d_i),
        .rs_1_e_i(rs_1_e_i), .rs_2_e_i(rs_2_e_i), .rd_e_i(rd_e_i),
        .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i),
        .mdu_start_e_i(mdu_start_e_i), .mdu_done_i(mdu_done_i),
        .rd_m_i(rd_m_i), .rd_w_i(rd_w_i),
        .we_reg_file_m_i(we_reg_file_m_i), .we_reg_file_w_i(we_reg_file_w_i),
        .cnt_clr_i(cnt_clr_i),
        .stall_f_o(l1_sf), .stall_d_o(l1_sd), .stall_e_o(l1_se),
        .flush_d_o(l1_fd), .flush_e_o(l1_fe),
        .forward_1e_o(l1_f1), .forward_2e_o(l1_f2),
        .cnt_stall_o(l1_cs), .cnt_flush_o(l1_cf)
    );

    // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e}
    typedef struct {
        int          cyc;
        logic [4:0]  ctl;
        logic [3:0]  fwd;
        logic [31:0] cs;
        logic [31:0] cf;
        logic        s1;
        logic [1:0]  cs1;
    } exp_t;

    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] LU = 5'b11001;
    localparam logic [4:0] MB = 5'b11100;
    localparam logic [4:0] BR = 5'b00011;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    logic [31:0] ecs = 0, ecf = 0;
    logic [1:0]  ecs1 = 0;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h want %0h", nm, c, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctl", e.cyc,
                {27'd0, stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o},
                {27'd0, e.ctl});
            chk("fwd", e.cyc, {28'd0, forward_1e_o, forward_2e_o},
                {28'd0, e.fwd});
            chk("cnt_stall", e.cyc, cnt_stall_o, e.cs);
            chk("cnt_flush", e.cyc, cnt_flush_o, e.cf);
            chk("l1_stall_f", e.cyc, {31'd0, l1_sf}, {31'd0, e.s1});
            chk("l1_cnt_stall", e.cyc, {30'd0, l1_cs}, {30'd0, e.cs1});
        end
    end

    task automatic idle();
        rs_1_d_i = 0; rs_2_d_i = 0; rs_1_e_i = 0; rs_2_e_i = 0;
        rd_e_i = 0; rd_m_i = 0; rd_w_i = 0;
        result_src_e_i = 0; pc_src_e_i = 0;
        mdu_start_e_i = 0; mdu_done_i = 0;
        we_reg_file_m_i = 0; we_reg_file_w_i = 0;
        cnt_clr_i = 0; rst_i = 0;
    endtask

    // Push this cycle's expectation, then advance one clock.
    task automatic cyc(input logic [4:0] ctl, input logic [3:0] fwd,
                       input logic s1);
        exp_t e;
        if (rst_i) begin
            ecs = 0; ecf = 0; ecs1 = 0;
        end
        e.cyc = ncyc; e.ctl = ctl; e.fwd = fwd;
        e.cs = ecs; e.cf = ecf; e.s1 = s1; e.cs1 = ecs1;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (rst_i || cnt_clr_i) begin
            ecs = 0; ecf = 0; ecs1 = 0;
        end else begin
            if (ctl[4] && ecs != 32'hFFFF_FFFF) ecs = ecs + 1;
            if ((ctl[1] || ctl[0]) && ecf != 32'hFFFF_FFFF) ecf = ecf + 1;
            if (s1 && ecs1 != 2'd3) ecs1 = ecs1 + 1;
        end
        ncyc++;
    endtask

    initial begin
        idle();
        rst_i = 1;
        @(posedge clk_i);
        #1;
        cyc(NO, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        // load-use on rs_2: 3 bubbles vs 1 bubble, pc_src ignored in wait
        result_src_e_i = 1; rd_e_i = 5; rs_2_d_i = 5;
        cyc(LU, 4'b0000, 1);
        result_src_e_i = 0; pc_src_e_i = 1;
        cyc(LU, 4'b0000, 0);
        pc_src_e_i = 0;
        cyc(LU, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        // load to x0 never stalls
        result_src_e_i = 1; rd_e_i = 0;
        cyc(NO, 4'b0000, 0);
        // load-use on rs_1
        rd_e_i = 9; rs_1_d_i = 9;
        cyc(LU, 4'b0000, 1);
        result_src_e_i = 0;
        cyc(LU, 4'b0000, 0);
        cyc(LU, 4'b0000, 0);
        // forwarding
        idle();
        rs_1_e_i = 7; rs_2_e_i = 7; rd_m_i = 7; rd_w_i = 7;
        we_reg_file_m_i = 1; we_reg_file_w_i = 1;
        cyc(NO, 4'b1010, 0);
        we_reg_file_m_i = 0;
        cyc(NO, 4'b0101, 0);
        rs_1_e_i = 0;
        cyc(NO, 4'b0001, 0);
        rs_1_e_i = 7; rs_2_e_i = 3; rd_w_i = 3; we_reg_file_m_i = 1;
        cyc(NO, 4'b1001, 0);
        // MDU busy 4 cycles, branch masked mid-busy
        idle();
        mdu_start_e_i = 1;
        cyc(MB, 4'b0000, 1);
        cyc(MB, 4'b0000, 1);
        pc_src_e_i = 1;
        cyc(MB, 4'b0000, 1);
        pc_src_e_i = 0;
        cyc(MB, 4'b0000, 1);
        mdu_done_i = 1;
        cyc(NO, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        mdu_start_e_i = 1; mdu_done_i = 1;
        cyc(NO, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        // branch wins over load-use
        pc_src_e_i = 1; result_src_e_i = 1; rd_e_i = 5; rs_2_d_i = 5;
        cyc(BR, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        // reset during MDU_BUSY
        mdu_start_e_i = 1;
        cyc(MB, 4'b0000, 1);
        rst_i = 1;
        cyc(NO, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        cyc(NO, 4'b0000, 0);
        // clear beats a concurrent stall
        mdu_start_e_i = 1; cnt_clr_i = 1;
        cyc(MB, 4'b0000, 1);
        cnt_clr_i = 0; mdu_done_i = 1;
        cyc(NO, 4'b0000, 0);
        idle();
        cyc(NO, 4'b0000, 0);
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk_i);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
